// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add 64-bit multiply sequenced over the shared ALU
module alu_mul_sequencer #(
    parameter int unsigned WIDTH     = 64,
    parameter logic [3:0]  CTRL_ADD  = 4'b0010,
    parameter logic [3:0]  CTRL_IDLE = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mplier == '0) begin
                        product <= acc;
                        state   <= ST_DONE;
                    end else begin
                        // The ALU is already adding acc + mcand this cycle; keep it only for a set multiplier bit.
                        if (mplier[0]) begin
                            acc <= alu_result;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

    // ALU ports are forced quiet while reset is held so an aborted run stops driving ADDs immediately.
    always_comb begin
        alu_in_1    = '0;
        alu_in_2    = '0;
        alu_control = CTRL_IDLE;
        if (!reset && state == ST_RUN) begin
            alu_in_1    = acc;
            alu_in_2    = mcand;
            alu_control = CTRL_ADD;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - directed self-checking bench for alu_mul_sequencer
module tb_alu_mul_sequencer;

    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] IDLE = 4'b0000;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [63:0] alu_in_1;
    logic [63:0] alu_in_2;
    logic [3:0]  alu_control;
    logic [63:0] alu_result;

    int vectors = 0;
    int miscompares = 0;

    alu_mul_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .alu_in_1    (alu_in_1),
        .alu_in_2    (alu_in_2),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    // Reference shared ALU: ADD or AND, combinational.
    assign alu_result = (alu_control == ADD) ? (alu_in_1 + alu_in_2) : (alu_in_1 & alu_in_2);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one multiply; latency is measured in cycles from the accepting edge to the done cycle.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_prod, input int exp_lat, input bit mid_start);
        int n;
        int bad;
        op_a = a;
        op_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        bad = 0;
        while (!done && n < 200) begin
            if (!busy || alu_control !== ADD) bad++;
            if (mid_start && n == 2) begin
                start = 1'b1;
                op_a = 64'd100;
                op_b = 64'd100;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " product"}, product, exp_prod);
        check({tag, " busy_at_done"}, {63'd0, busy}, 64'd1);
        check({tag, " run_ctrl_errors"}, 64'(bad), 64'd0);
        tick();
        check({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
        check({tag, " idle_done"}, {63'd0, done}, 64'd0);
        check({tag, " product_hold"}, product, exp_prod);
    endtask

    initial begin
        int n;
        int dones;
        reset = 1'b1;
        start = 1'b0;
        op_a = '0;
        op_b = '0;
        tick();
        tick();
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset product", product, 64'd0);
        check("reset alu_control", {60'd0, alu_control}, {60'd0, IDLE});
        reset = 1'b0;
        tick();
        check("idle alu_in_1", alu_in_1, 64'd0);
        check("idle alu_in_2", alu_in_2, 64'd0);

        run_op("basic 6x7", 64'd6, 64'd7, 64'd42, 5, 1'b0);
        run_op("zero mplier", ALL1, 64'd0, 64'd0, 2, 1'b0);
        run_op("wrap", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 4, 1'b0);
        run_op("max", ALL1, ALL1, 64'd1, 66, 1'b0);
        run_op("ignored start", 64'd11, 64'd13, 64'd143, 6, 1'b1);

        // Abort a max-operand run with reset during cycle T+10.
        op_a = ALL1;
        op_b = ALL1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("abort busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort alu_control_in_reset", {60'd0, alu_control}, {60'd0, IDLE});
        tick();
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort product", product, 64'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort no_done", 64'(dones), 64'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        op_a = 64'd5;
        op_b = 64'd5;
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("reset_vs_start busy", {63'd0, busy}, 64'd0);

        // Back-to-back with start held high.
        dones = 0;
        op_a = 64'd3;
        op_b = 64'd5;
        start = 1'b1;
        tick();
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (done) dones++;
        check("b2b first product", product, 64'd15);
        op_a = 64'd9;
        op_b = 64'd9;
        tick();
        check("b2b idle gap busy", {63'd0, busy}, 64'd0);
        tick();
        check("b2b second run busy", {63'd0, busy}, 64'd1);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (done) dones++;
        start = 1'b0;
        check("b2b second product", product, 64'd81);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        check("b2b done count", 64'(dones), 64'd2);
        check("b2b product stable", product, 64'd81);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
